// File: rtl/led_scanner_pkg.sv
// Shared encodings for the LED bar scanner: runtime mode select and FSM states.
package led_scanner_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_WRAP_L = 2'b01,
    MODE_WRAP_R = 2'b10,
    MODE_FREEZE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_MOVE_L = 2'b00,
    ST_MOVE_R = 2'b01,
    ST_HOLD   = 2'b10
  } state_e;

  localparam int unsigned DWELL_W = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider: one registered TICK every max(PERIOD,1) enabled cycles.
module led_tick_gen
  import led_scanner_pkg::*;
#(
  parameter int unsigned DIV_W = 24
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [DIV_W-1:0] PERIOD,
  output logic             TICK
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] per_q;
  logic [DIV_W-1:0] per_eff;
  logic             wrap;

  // PERIOD is taken live only on the first count of a period and held in per_q afterwards.
  always_comb begin
    per_eff = per_q;
    if (cnt_q == '0) begin
      per_eff = (PERIOD == '0) ? DIV_W'(1) : PERIOD;
    end
    wrap = (cnt_q == per_eff - DIV_W'(1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      per_q <= '0;
      TICK  <= 1'b0;
    end else if (EN) begin
      TICK <= wrap;
      if (cnt_q == '0) begin
        per_q <= per_eff;
      end
      cnt_q <= wrap ? '0 : cnt_q + DIV_W'(1);
    end else begin
      TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/led_scanner.sv
// Knight Rider style LED bar scanner with bounce/wrap/freeze modes, end dwell and status.
module led_scanner
  import led_scanner_pkg::*;
#(
  parameter int unsigned N_LEDS   = 10,
  parameter int unsigned BAR_W    = 3,
  parameter int unsigned OVERSCAN = 2,
  parameter int unsigned DIV_W    = 24
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic [DIV_W-1:0]  PERIOD,
  input  logic [3:0]        DWELL,
  output logic [N_LEDS-1:0] LED_array,
  output logic              DIR,
  output logic              END_PULSE,
  output logic              TICK
);

  localparam int unsigned    E         = N_LEDS + 2 * OVERSCAN;
  localparam logic [E-1:0]   RESET_PAT = {E{1'b1}} >> (E - BAR_W);
  localparam bit             FULL      = (BAR_W == E);

  logic               tick;
  logic               step;
  mode_e              mode;
  state_e             state_q, state_d;
  logic [E-1:0]       pat_q, pat_d;
  logic               dir_q, dir_d;
  logic               endp_q, endp_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               go_left;
  logic               hit_end;
  logic [E-1:0]       step_pat;

  led_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .EN     (EN),
    .PERIOD (PERIOD),
    .TICK   (tick)
  );

  always_comb begin
    mode     = mode_e'(MODE);
    step     = tick & EN;
    pat_d    = pat_q;
    state_d  = state_q;
    dir_d    = dir_q;
    dwell_d  = dwell_q;
    endp_d   = 1'b0;
    // A bar already sitting on the edge it is heading for turns round instead of clipping.
    go_left  = (state_q == ST_MOVE_L) ? !pat_q[E-1] : pat_q[0];
    step_pat = go_left ? (pat_q << 1) : (pat_q >> 1);
    hit_end  = go_left ? step_pat[E-1] : step_pat[0];

    if (step && !FULL) begin
      case (mode)
        MODE_WRAP_L: begin
          pat_d   = (pat_q << 1) | (pat_q >> (E - 1));
          dir_d   = 1'b0;
          state_d = ST_MOVE_L;
        end
        MODE_WRAP_R: begin
          pat_d   = (pat_q >> 1) | (pat_q << (E - 1));
          dir_d   = 1'b1;
          state_d = ST_MOVE_R;
        end
        MODE_FREEZE: begin
          pat_d = pat_q;
        end
        MODE_BOUNCE: begin
          if (pat_q[0] && pat_q[E-1]) begin
            pat_d   = RESET_PAT;
            dir_d   = 1'b0;
            state_d = ST_MOVE_L;
          end else if (state_q == ST_HOLD) begin
            dwell_d = (dwell_q != '0) ? dwell_q - DWELL_W'(1) : '0;
            if (dwell_q <= DWELL_W'(1)) begin
              state_d = dir_q ? ST_MOVE_R : ST_MOVE_L;
            end
          end else begin
            pat_d = step_pat;
            if (hit_end) begin
              endp_d  = 1'b1;
              dir_d   = go_left;
              dwell_d = DWELL;
              if (DWELL != '0) begin
                state_d = ST_HOLD;
              end else begin
                state_d = go_left ? ST_MOVE_R : ST_MOVE_L;
              end
            end else begin
              dir_d   = !go_left;
              state_d = go_left ? ST_MOVE_L : ST_MOVE_R;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pat_q   <= RESET_PAT;
      state_q <= ST_MOVE_L;
      dir_q   <= 1'b0;
      dwell_q <= '0;
      endp_q  <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      dwell_q <= dwell_d;
      endp_q  <= endp_d;
    end
  end

  assign LED_array = pat_q[OVERSCAN +: N_LEDS];
  assign DIR       = dir_q;
  assign END_PULSE = endp_q;
  assign TICK      = tick;

endmodule
